// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: op/state encodings and
// alignment/size classification used by both the controller and the lane logic.
package lsu_pkg;

    localparam int DATA_W = 32;
    localparam int IDX_W  = 5;

    typedef enum logic [2:0] {
        OP_LW  = 3'd0,
        OP_LB  = 3'd1,
        OP_LBU = 3'd2,
        OP_LH  = 3'd3,
        OP_LHU = 3'd4,
        OP_SW  = 3'd5,
        OP_SB  = 3'd6,
        OP_SH  = 3'd7
    } lsu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RMW_RD = 3'd2,
        ST_WRITE  = 3'd3,
        ST_RESP   = 3'd4
    } lsu_state_t;

    function automatic logic is_load(lsu_op_t op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
               (op == OP_LH) || (op == OP_LHU);
    endfunction

    function automatic logic is_sub_word(lsu_op_t op);
        return !((op == OP_LW) || (op == OP_SW));
    endfunction

    function automatic logic is_half(lsu_op_t op);
        return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
    endfunction

    function automatic logic is_misaligned(lsu_op_t op, logic [1:0] off);
        if (is_half(op)) begin
            return off[0];
        end else if (!is_sub_word(op)) begin
            return off != 2'b00;
        end
        return 1'b0;
    endfunction

    // Rounds a byte offset down to the natural alignment of the access size.
    function automatic logic [1:0] force_align(lsu_op_t op, logic [1:0] off);
        if (is_half(op)) begin
            return {off[1], 1'b0};
        end else if (!is_sub_word(op)) begin
            return 2'b00;
        end
        return off;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane logic: extracts and extends load data from a memory word, and
// merges store data into a word for read-modify-write.
module lsu_lane
    import lsu_pkg::*;
(
    input  lsu_op_t     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] word_i,
    input  logic [31:0] sdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        shamt   = {off_i, 3'b000};
        shifted = word_i >> shamt;
        load_o  = '0;
        mask    = '0;
        ins     = '0;
        case (op_i)
            OP_LW:  load_o = word_i;
            OP_LB:  load_o = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU: load_o = {24'b0, shifted[7:0]};
            OP_LH:  load_o = {{16{shifted[15]}}, shifted[15:0]};
            OP_LHU: load_o = {16'b0, shifted[15:0]};
            OP_SW: begin
                mask = '1;
                ins  = sdata_i;
            end
            OP_SB: begin
                mask = 32'h0000_00FF << shamt;
                ins  = {24'b0, sdata_i[7:0]} << shamt;
            end
            OP_SH: begin
                mask = 32'h0000_FFFF << shamt;
                ins  = {16'b0, sdata_i[15:0]} << shamt;
            end
            default: ;
        endcase
        // Lanes outside the mask keep the word read from memory.
        merge_o = (word_i & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller FSM between execute and a 32-word memory.
// Build option: LSU_ALIGN_CHECK_EN enables misalignment errors; otherwise low address bits are forced aligned.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ena,
    output logic              mem_worr,
    output logic [4:0]        mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    lsu_state_t  state_q;
    lsu_op_t     op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        req_ready_q;
    logic        resp_valid_q;
    logic        mem_ena_q;
    logic        mem_worr_q;
    logic [4:0]  mem_addr_q;
    logic [31:0] mem_wdata_q;

    lsu_op_t     op_d;
    logic [1:0]  off_d;
    logic        misalign_d;
    logic [31:0] lane_load;
    logic [31:0] lane_merge;

    always_comb begin
        op_d       = lsu_op_t'(req_op);
        misalign_d = ALIGN_CHECK && is_misaligned(op_d, req_addr[1:0]);
        off_d      = ALIGN_CHECK ? req_addr[1:0] : force_align(op_d, req_addr[1:0]);
    end

    lsu_lane u_lane (
        .op_i    (op_q),
        .off_i   (off_q),
        .word_i  (mem_rdata),
        .sdata_i (wdata_q),
        .load_o  (lane_load),
        .merge_o (lane_merge)
    );

    // All outputs, including the memory strobes, are registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_q         <= OP_LW;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            mem_ena_q    <= 1'b0;
            mem_worr_q   <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q        <= op_d;
                        off_q       <= off_d;
                        wdata_q     <= req_wdata;
                        mem_addr_q  <= req_addr[6:2];
                        rdata_q     <= '0;
                        err_q       <= 1'b0;
                        req_ready_q <= 1'b0;
                        if (misalign_d) begin
                            err_q        <= 1'b1;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (is_load(op_d)) begin
                            mem_ena_q  <= 1'b1;
                            mem_worr_q <= 1'b0;
                            state_q    <= ST_LOAD;
                        end else if (op_d == OP_SW) begin
                            mem_ena_q   <= 1'b1;
                            mem_worr_q  <= 1'b1;
                            mem_wdata_q <= req_wdata;
                            state_q     <= ST_WRITE;
                        end else begin
                            mem_ena_q  <= 1'b1;
                            mem_worr_q <= 1'b0;
                            state_q    <= ST_RMW_RD;
                        end
                    end
                end
                ST_LOAD: begin
                    rdata_q      <= lane_load;
                    mem_ena_q    <= 1'b0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RMW_RD: begin
                    mem_worr_q  <= 1'b1;
                    mem_wdata_q <= lane_merge;
                    state_q     <= ST_WRITE;
                end
                ST_WRITE: begin
                    mem_ena_q    <= 1'b0;
                    mem_worr_q   <= 1'b0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    mem_ena_q    <= 1'b0;
                    mem_worr_q   <= 1'b0;
                    mem_wdata_q  <= '0;
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_ena    = mem_ena_q;
    assign mem_worr   = mem_worr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard testbench for lsu_ctrl: a byte-array reference memory predicts each
// response, and a monitor pops and compares whenever the DUT presents one.
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [6:0]  req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ena;
    logic        mem_worr;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_ctrl #(.ADDR_W(7)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ena    (mem_ena),
        .mem_worr   (mem_worr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory device driven by the DUT, plus the independent reference copy.
    logic [31:0] mem    [32];
    logic [31:0] refMem [32];

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_ena && mem_worr) mem[mem_addr] = mem_wdata;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          accept;
        int          lat;
    } exp_t;

    exp_t sbQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;
    int writeCount  = 0;
    int memEnaCount = 0;
    int forceHold   = 0;
    logic [4:0]  lastWAddr;
    logic [31:0] lastWData;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: works on bytes of the word, size-based alignment.
    function automatic void refAccess(input lsu_op_t op, input logic [6:0] addr, input logic [31:0] wd,
                                      output logic [31:0] rd, output logic err, output int lat);
        int          off;
        int          idx;
        int          size;
        logic [7:0]  bytes [4];
        longint      v;
        logic [31:0] w;
        off  = int'(addr[1:0]);
        idx  = int'(addr[6:2]);
        size = (op == OP_LW || op == OP_SW) ? 4 : (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2 : 1;
        rd   = '0;
        err  = 1'b0;
        lat  = 0;
`ifdef LSU_ALIGN_CHECK_EN
        if ((off % size) != 0) begin
            err = 1'b1;
            lat = 1;
            return;
        end
`else
        off = off - (off % size);
`endif
        w = refMem[idx];
        for (int k = 0; k < 4; k++) bytes[k] = 8'((w >> (8 * k)) & 32'hFF);
        if (op == OP_LW || op == OP_LB || op == OP_LBU || op == OP_LH || op == OP_LHU) begin
            v = 0;
            for (int k = 0; k < size; k++) v = v + (longint'(bytes[off + k]) << (8 * k));
            if ((op == OP_LB || op == OP_LH) && v >= (longint'(1) << (8 * size - 1)))
                v = v - (longint'(1) << (8 * size));
            rd  = v[31:0];
            lat = 2;
        end else begin
            for (int k = 0; k < size; k++) bytes[off + k] = 8'((wd >> (8 * k)) & 32'hFF);
            refMem[idx] = {bytes[3], bytes[2], bytes[1], bytes[0]};
            lat = (op == OP_SW) ? 2 : 3;
        end
    endfunction

    // Monitor / consumer: pops expectations, checks stability and backpressure.
    logic        inResp = 1'b0;
    int          holdLeft = 0;
    logic [31:0] heldRdata;
    logic        heldErr;

    always @(negedge clk) begin
        if (mem_ena && mem_worr) begin
            writeCount++;
            lastWAddr = mem_addr;
            lastWData = mem_wdata;
        end else begin
            checkOutput("mem_wdata_zero_when_not_writing", mem_wdata, 32'h0);
        end
        if (mem_ena) memEnaCount++;

        if (!rst_n) begin
            inResp     = 1'b0;
            resp_ready = 1'b0;
        end else if (resp_valid) begin
            if (!inResp) begin
                if (sbQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cycle);
                end else begin
                    exp_t e;
                    e = sbQ.pop_front();
                    checkOutput("resp_rdata", resp_rdata, e.rdata);
                    checkOutput("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    checkOutput("resp_latency", cycle - e.accept + 1, e.lat);
                end
                heldRdata = resp_rdata;
                heldErr   = resp_err;
                inResp    = 1'b1;
                holdLeft  = (forceHold > 0) ? forceHold : int'($urandom_range(0, 3));
                forceHold = 0;
            end else begin
                checkOutput("hold_rdata", resp_rdata, heldRdata);
                checkOutput("hold_err", {31'b0, resp_err}, {31'b0, heldErr});
            end
            checkOutput("req_ready_low_in_resp", {31'b0, req_ready}, 32'h0);
            if (holdLeft == 0) begin
                resp_ready = 1'b1;
            end else begin
                resp_ready = 1'b0;
                holdLeft--;
            end
        end else begin
            if (inResp) checkOutput("idle_after_resp", {31'b0, req_ready}, 32'h1);
            inResp     = 1'b0;
            resp_ready = 1'b0;
        end
    end

    task automatic applyStimulus(input lsu_op_t op, input logic [6:0] addr, input logic [31:0] wd);
        int          n;
        exp_t        e;
        logic [31:0] rd;
        logic        err;
        int          lat;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL req_ready_timeout: got req_ready=0 expected 1 within 100 cycles");
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        refAccess(op, addr, wd, rd, err, lat);
        e.rdata  = rd;
        e.err    = err;
        e.accept = cycle + 1;
        e.lat    = lat;
        sbQ.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = 3'($urandom);
        req_addr  = 7'($urandom);
        req_wdata = $urandom;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (!(sbQ.size() == 0 && req_ready && !resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL drain_timeout: got %0d pending responses expected 0", sbQ.size());
        end
    endtask

    task automatic setWord(input int idx, input logic [31:0] val);
        mem[idx]    = val;
        refMem[idx] = val;
    endtask

    initial begin
        int wc0;
        int en0;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 7'd0;
        req_wdata = 32'd0;
        for (int i = 0; i < 32; i++) setWord(i, $urandom);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_resp_err", {31'b0, resp_err}, 32'h0);
        checkOutput("rst_mem_ena", {31'b0, mem_ena}, 32'h0);
        checkOutput("rst_mem_worr", {31'b0, mem_worr}, 32'h0);
        checkOutput("rst_mem_addr", {27'b0, mem_addr}, 32'h0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_req_ready", {31'b0, req_ready}, 32'h1);
        checkOutput("post_rst_mem_ena", {31'b0, mem_ena}, 32'h0);

        wc0 = writeCount;
        applyStimulus(OP_SW, 7'h08, 32'hDEADBEEF);
        waitDrain();
        checkOutput("sw_write_cycles", writeCount - wc0, 1);
        checkOutput("sw_mem_addr", {27'b0, lastWAddr}, 32'd2);
        checkOutput("sw_mem_wdata", lastWData, 32'hDEADBEEF);
        checkOutput("sw_mem_word", mem[2], 32'hDEADBEEF);

        setWord(2, 32'h8899AABB);
        applyStimulus(OP_LB,  7'h0A, 32'h0);
        applyStimulus(OP_LBU, 7'h0A, 32'h0);
        applyStimulus(OP_LH,  7'h0A, 32'h0);
        applyStimulus(OP_LHU, 7'h08, 32'h0);
        waitDrain();

        setWord(2, 32'h11223344);
        applyStimulus(OP_SB, 7'h09, 32'h000000A5);
        applyStimulus(OP_SH, 7'h0A, 32'h0000BEEF);
        waitDrain();
        checkOutput("sb_sh_word", mem[2], 32'hBEEFA544);

        setWord(1, 32'h13579BDF);
        en0 = memEnaCount;
        applyStimulus(OP_LW, 7'h05, 32'h0);
        waitDrain();
`ifdef LSU_ALIGN_CHECK_EN
        checkOutput("misaligned_no_mem_access", memEnaCount - en0, 0);
`else
        checkOutput("forced_align_one_read", memEnaCount - en0, 1);
`endif

        forceHold = 5;
        applyStimulus(OP_LW, 7'h10, 32'h0);
        waitDrain();

        // Reset while the read half of a read-modify-write is in progress.
        setWord(3, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = OP_SB;
        req_addr  = 7'h0D;
        req_wdata = 32'h00000077;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("rmw_rd_mem_ena", {31'b0, mem_ena}, 32'h1);
        wc0 = writeCount;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rmw_rst_mem_ena_drop", {31'b0, mem_ena}, 32'h0);
        checkOutput("rmw_rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        checkOutput("rmw_rst_req_ready", {31'b0, req_ready}, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rmw_rst_no_write", writeCount - wc0, 0);
        checkOutput("rmw_rst_mem_unchanged", mem[3], 32'hCAFEF00D);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(lsu_op_t'(3'($urandom_range(0, 7))), 7'($urandom_range(0, 127)), $urandom);
        end
        waitDrain();
        for (int i = 0; i < 32; i++) checkOutput("final_mem_word", mem[i], refMem[i]);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000ns");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store control unit between the CPU execute stage and the 32-word data memory. Accepts one byte-addressed load or store per request over a valid/ready handshake and translates it into word-addressed memory accesses. Byte and halfword loads are extracted and sign- or zero-extended; byte and halfword stores are done as read-modify-write. It also checks alignment and returns a single response per request.

## Interface
- `ADDR_W`, default 7, byte-address width (32 words × 4 bytes).
- `clk`  input  1  clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  request present.
- `req_ready`  output  1  unit can accept a request.
- `req_op`  input  3  operation code (`lsu_op_t`).
- `req_addr`  input  ADDR_W  byte address.
- `req_wdata`  input  32  store data, right-justified.
- `resp_valid`  output  1  response present.
- `resp_ready`  input  1  consumer accepts the response.
- `resp_rdata`  output  32  load result, extended; 0 for stores.
- `resp_err`  output  1  misaligned request, no memory access made.
- `mem_ena`  output  1  memory enable.
- `mem_worr`  output  1  1 = write, 0 = read.
- `mem_addr`  output  5  word index, `req_addr[6:2]`.
- `mem_wdata`  output  32  word to write.
- `mem_rdata`  input  32  combinational read data. Valid in the same cycle as `mem_ena=1, mem_worr=0`.

## Operation
- Op encoding:
  - LW=0, LB=1, LBU=2, LH=3, LHU=4, SW=5, SB=6, SH=7.
  - Little-endian: byte offset 0 is `[7:0]`. Halfword at offset 0 is `[15:0]`; at offset 2 it is `[31:16]`.
- States: IDLE, LOAD, RMW_RD, WRITE, RESP.
- IDLE:
  - `req_ready=1`.
  - On `req_valid`, latch op, addr and wdata.
  - Misaligned → RESP with err=1. Misaligned means a halfword op with `addr[0]=1`, or a word op with `addr[1:0]≠0`.
  - Load → LOAD. SW → WRITE, with merged word = wdata. SB/SH → RMW_RD.
- LOAD:
  - Drive `mem_ena=1, mem_worr=0`.
  - Register the extracted and extended result into `resp_rdata` → RESP.
- RMW_RD:
  - Drive a read.
  - Register `mem_rdata` with the target lane replaced by `wdata[7:0]` (SB) or `wdata[15:0]` (SH). Other lanes are preserved.
  - → WRITE.
- WRITE: drive `mem_ena=1, mem_worr=1, mem_wdata=merged` → RESP. Memory commits at the edge that leaves WRITE.
- RESP:
  - `resp_valid=1`, with `resp_rdata`/`resp_err` held stable.
  - On `resp_ready` → IDLE.
  - Holds indefinitely under backpressure.
- `mem_*` are decoded from the state register only, so there are no combinational paths from `req_*` or `resp_ready`.
  - `mem_ena=0` in IDLE and RESP.
  - `mem_wdata=0` when not writing.
- A new request is not accepted in the cycle RESP is left; there is no pipelining and at most one request in flight.

## Timing
- Reset, asynchronous:
  - state=IDLE, `req_ready=1`, `resp_valid=0`, `resp_rdata=0`, `resp_err=0`.
  - `mem_ena=0`, `mem_worr=0`, `mem_addr=0`, `mem_wdata=0`.
- Cycles from the request-accept edge to `resp_valid` high:
  - Loads and SW: 2.
  - SB/SH: 3.
  - Misaligned: 1.
- Reset mid-operation:
  - `mem_ena` drops immediately and the request is discarded with no response.
  - A write in WRITE whose commit edge has not occurred is lost.
- Request presented while in RESP: not accepted, because `req_ready=0`; it is taken after returning to IDLE.

## Configuration
- Macro: `LSU_ALIGN_CHECK_EN`.
- Defined: misalignment detection as above. `resp_err` can assert and no memory access is made.
- Undefined:
  - No check; `resp_err` is tied 0.
  - Low address bits are forced to alignment (halfword: `addr[0]=0`; word: `addr[1:0]=0`) before lane selection.

## Structure
- Package `lsu_pkg` holds:
  - `lsu_op_t` enum.
  - `lsu_state_t` enum.
  - Helper functions `is_load`, `is_sub_word`.
- Sub-module `lsu_lane` (combinational): load extract/extend and store merge. Inputs: op, offset, word, store data.
- Top `lsu_ctrl` holds the FSM, the latched request and the response registers.

## Test plan
- Reset with `rst_n=0`, then release → all outputs at reset values. SW addr 0x08, data 0xDEADBEEF → one write cycle with `mem_addr=2`, `mem_wdata=0xDEADBEEF`; `resp_valid` on cycle 2.
- Memory word 2 = 0x8899AABB:
  - LB 0x0A → 0xFFFFFF99.
  - LBU 0x0A → 0x00000099.
  - LH 0x0A → 0xFFFF8899.
  - LHU 0x08 → 0x0000AABB.
- Word 2 = 0x11223344:
  - SB 0x09, data 0xA5 → word becomes 0x1122A544.
  - SH 0x0A, data 0xBEEF → word becomes 0xBEEFA544.
  - Each response arrives 3 cycles after accept.
- With `LSU_ALIGN_CHECK_EN`: LW 0x05 → `resp_err=1` after 1 cycle, `mem_ena` never asserted. Without the macro: same request reads word 1.
- `resp_ready=0` for 5 cycles after a load → `resp_valid` and `resp_rdata` stay stable, `req_ready=0`. Release → IDLE next cycle.
- Assert `rst_n=0` while in RMW_RD → `mem_ena` drops immediately, no write occurs, no response is issued, and target memory is unchanged.
